sm4_iter_core: RTL and testbench

Sequential SM4 block cipher engine. It computes UNROLL rounds per clock and uses valid/ready handshakes on key, input and output. It expands round keys on the fly instead of holding 32 round keys. Encryption runs the key schedule forwards; decryption runs the key schedule backwards from stored final key words K32..K35. It sits beside the combinational SM4 datapath as the area-efficient, registered alternative for streaming blocks.

---
 rtl/sm4_iter_core.sv | 192 +++++++++++++++++++
 tb/tb_sm4_iter_core.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm4_iter_core.sv
// Iterative SM4 engine: UNROLL rounds per clock, round keys generated on the fly.
// Encryption walks the key schedule forwards from K0..K3; decryption walks it backwards from K32..K35.
module sm4_iter_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [127:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dout,
  output logic         busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
    $error("sm4_iter_core: UNROLL must be 1, 2 or 4");
  end

  typedef enum logic [2:0] {IDLE, KEYEXP, READY, RUN, DONE} state_e;

  localparam logic [127:0] FK   = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
  localparam logic [4:0]   STEP = 5'(UNROLL);

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] sbox_word(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  function automatic logic [31:0] t_key(input logic [31:0] a);
    logic [31:0] b;
    b = sbox_word(a);
    return b ^ rol(b, 13) ^ rol(b, 23);
  endfunction

  function automatic logic [31:0] t_enc(input logic [31:0] a);
    logic [31:0] b;
    b = sbox_word(a);
    return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
  endfunction

  function automatic logic [31:0] ck_word(input logic [4:0] i);
    logic [31:0] ck;
    for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'((4 * int'(i) + j) * 7);
    return ck;
  endfunction

  // Key window k holds four consecutive round-key words, oldest in [127:96].
  // Backwards, the word leaving the window's tail is the round key just consumed.
  function automatic logic [255:0] advance(input logic [127:0] kw, input logic [127:0] xw,
                                           input logic [4:0] r, input logic fwd);
    logic [127:0] k;
    logic [127:0] x;
    logic [31:0]  nk;
    logic [31:0]  rk;
    logic [4:0]   i;
    k = kw;
    x = xw;
    for (int u = 0; u < UNROLL; u++) begin
      i = r + 5'(u);
      if (fwd) begin
        nk = k[127:96] ^ t_key(k[95:64] ^ k[63:32] ^ k[31:0] ^ ck_word(i));
        rk = nk;
        k  = {k[95:0], nk};
      end else begin
        i  = 5'd31 - i;
        nk = k[31:0] ^ t_key(k[127:96] ^ k[95:64] ^ k[63:32] ^ ck_word(i));
        rk = k[31:0];
        k  = {nk, k[127:32]};
      end
      x = {x[95:0], x[127:96] ^ t_enc(x[95:64] ^ x[63:32] ^ x[31:0] ^ rk)};
    end
    return {k, x};
  endfunction

  state_e       state_q, state_d;
  logic [4:0]   rnd_q, rnd_d;
  logic [127:0] k_q, k_d, x_q, x_d;
  logic [127:0] enc_seed_q, enc_seed_d, dec_seed_q, dec_seed_d;
  logic [127:0] dout_q, dout_d;
  logic         mode_q, mode_d;
  logic [127:0] k_adv, x_adv;
  logic         last_step;

  assign key_ready = (state_q == IDLE) || (state_q == READY);
  assign in_ready  = (state_q == READY) && !key_valid;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == KEYEXP) || (state_q == RUN);
  assign dout      = dout_q;

  assign {k_adv, x_adv} = advance(k_q, x_q, rnd_q, (state_q == KEYEXP) || mode_q);
  assign last_step      = ({1'b0, rnd_q} + {1'b0, STEP}) == 6'd32;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    rnd_d      = rnd_q;
    k_d        = k_q;
    x_d        = x_q;
    enc_seed_d = enc_seed_q;
    dec_seed_d = dec_seed_q;
    dout_d     = dout_q;
    mode_d     = mode_q;
    unique case (state_q)
      IDLE, READY: begin
        if (key_valid) begin
          k_d        = key ^ FK;
          enc_seed_d = key ^ FK;
          rnd_d      = '0;
          state_d    = KEYEXP;
        end else if (in_valid && state_q == READY) begin
          x_d     = din;
          mode_d  = mode;
          k_d     = mode ? enc_seed_q : dec_seed_q;
          rnd_d   = '0;
          state_d = RUN;
        end
      end
      KEYEXP: begin
        k_d   = k_adv;
        rnd_d = rnd_q + STEP;
        if (last_step) begin
          dec_seed_d = k_adv;
          state_d    = READY;
        end
      end
      RUN: begin
        k_d   = k_adv;
        x_d   = x_adv;
        rnd_d = rnd_q + STEP;
        if (last_step) begin
          dout_d  = {x_adv[31:0], x_adv[63:32], x_adv[95:64], x_adv[127:96]};
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = READY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath and seed registers are cleared too, so no X can ever reach dout.
      state_q    <= IDLE;
      rnd_q      <= '0;
      k_q        <= '0;
      x_q        <= '0;
      enc_seed_q <= '0;
      dec_seed_q <= '0;
      dout_q     <= '0;
      mode_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q    <= state_d;
      rnd_q      <= rnd_d;
      k_q        <= k_d;
      x_q        <= x_d;
      enc_seed_q <= enc_seed_d;
      dec_seed_q <= dec_seed_d;
      dout_q     <= dout_d;
      mode_q     <= mode_d;
    end
  end

endmodule

// File: tb/tb_sm4_iter_core.sv
// Bench for sm4_iter_core: one instance each of UNROLL=1,2,4, directed SM4 vectors
// plus randomized key/block pairs checked against a whole-array SM4 reference model.
module tb_sm4_iter_core;

  localparam logic [127:0] GOLD_KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] GOLD_CT  = 128'h681edf34d206965e86b3e94f536e4246;
  localparam int N_RAND [3] = '{100, 200, 400};

  localparam logic [7:0] SB [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  logic         clk;
  logic [2:0]   rst, key_valid, key_ready, in_valid, in_ready, mode, out_valid, out_ready, busy;
  logic [127:0] key_in [3];
  logic [127:0] din    [3];
  logic [127:0] dout   [3];

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sm4_iter_core #(.UNROLL(1 << g)) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .key_valid(key_valid[g]),
      .key_ready(key_ready[g]),
      .key      (key_in[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .mode     (mode[g]),
      .din      (din[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .dout     (dout[g]),
      .busy     (busy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: straight from the SM4 equations ----------------
  function automatic logic [31:0] m_rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] m_tau(input logic [31:0] a);
    return {SB[a[31:24]], SB[a[23:16]], SB[a[15:8]], SB[a[7:0]]};
  endfunction

  function automatic logic [127:0] sm4_model(input logic [127:0] k_in, input logic [127:0] blk, input bit enc);
    logic [31:0] k [36];
    logic [31:0] x [36];
    logic [31:0] rk [32];
    logic [31:0] fk [4];
    logic [31:0] b, ck;
    fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
    for (int w = 0; w < 4; w++) begin
      k[w] = k_in[127-32*w -: 32] ^ fk[w];
      x[w] = blk[127-32*w -: 32];
    end
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
      b = m_tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ b ^ m_rol(b, 13) ^ m_rol(b, 23);
    end
    for (int i = 0; i < 32; i++) rk[i] = enc ? k[i+4] : k[35-i];
    for (int i = 0; i < 32; i++) begin
      b = m_tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk[i]);
      x[i+4] = x[i] ^ b ^ m_rol(b, 2) ^ m_rol(b, 10) ^ m_rol(b, 18) ^ m_rol(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load_key(input int i, input logic [127:0] k);
    int n;
    n = 0;
    while (!key_ready[i] && n < 200) begin tick(); n++; end
    key_in[i]    = k;
    key_valid[i] = 1'b1;
    tick();
    key_valid[i] = 1'b0;
    key_in[i]    = rand128();
    n = 0;
    while (!in_ready[i] && n < 200) begin tick(); n++; end
    check($sformatf("u%0d keyexp_latency", 1 << i), 128'(n), 128'(32 >> i));
  endtask

  task automatic run_block(input int i, input logic [127:0] blk, input bit m, input int stall,
                           output logic [127:0] res);
    int n;
    n = 0;
    while (!in_ready[i] && n < 200) begin tick(); n++; end
    din[i]      = blk;
    mode[i]     = m;
    in_valid[i] = 1'b1;
    tick();
    in_valid[i] = 1'b0;
    din[i]      = rand128();
    mode[i]     = ~m;
    n = 0;
    while (!out_valid[i] && n < 200) begin tick(); n++; end
    check($sformatf("u%0d block_latency", 1 << i), 128'(n), 128'(32 >> i));
    res = dout[i];
    repeat (stall) tick();
    out_ready[i] = 1'b1;
    tick();
    out_ready[i] = 1'b0;
    check($sformatf("u%0d release{ov,ir}", 1 << i), 128'({out_valid[i], in_ready[i]}), 128'(2'b01));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] res, res2, k, blk, d0;
    int bad;
    rst = '1; key_valid = '0; in_valid = '0; mode = '0; out_ready = '0;
    for (int i = 0; i < 3; i++) begin key_in[i] = '0; din[i] = '0; end
    tick(); tick();
    rst = '0;

    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d reset{kr,ir,ov,busy}", 1 << i),
            128'({key_ready[i], in_ready[i], out_valid[i], busy[i]}), 128'(4'b1000));
      check($sformatf("u%0d reset dout", 1 << i), dout[i], '0);
    end

    for (int i = 0; i < 3; i++) begin
      // golden encrypt / decrypt, then same key reused for both directions
      load_key(i, GOLD_KEY);
      run_block(i, GOLD_KEY, 1'b1, 0, res);
      check($sformatf("u%0d golden_enc", 1 << i), res, GOLD_CT);
      run_block(i, GOLD_CT, 1'b0, 2, res);
      check($sformatf("u%0d golden_dec", 1 << i), res, GOLD_KEY);

      // backpressure: result held, key and block offers ignored
      din[i] = GOLD_KEY; mode[i] = 1'b1; in_valid[i] = 1'b1;
      tick();
      in_valid[i] = 1'b0;
      bad = 0;
      while (!out_valid[i] && bad < 200) begin tick(); bad++; end
      d0 = dout[i];
      check($sformatf("u%0d bp first dout", 1 << i), d0, GOLD_CT);
      key_in[i] = rand128(); key_valid[i] = 1'b1; din[i] = rand128(); in_valid[i] = 1'b1;
      for (int c = 0; c < 10; c++) begin
        tick();
        check($sformatf("u%0d bp dout c%0d", 1 << i, c), dout[i], d0);
        check($sformatf("u%0d bp{ov,ir,kr} c%0d", 1 << i, c),
              128'({out_valid[i], in_ready[i], key_ready[i]}), 128'(3'b100));
      end
      key_valid[i] = 1'b0; in_valid[i] = 1'b0;
      out_ready[i] = 1'b1;
      tick();
      out_ready[i] = 1'b0;
      check($sformatf("u%0d bp release{ov,ir}", 1 << i), 128'({out_valid[i], in_ready[i]}), 128'(2'b01));
      run_block(i, GOLD_KEY, 1'b1, 0, res);
      check($sformatf("u%0d bp key kept", 1 << i), res, GOLD_CT);

      // key and block offered together in READY: key wins
      key_in[i] = '0; key_valid[i] = 1'b1;
      blk = rand128(); din[i] = blk; mode[i] = 1'b1; in_valid[i] = 1'b1;
      #1;
      check($sformatf("u%0d prio{kr,ir}", 1 << i), 128'({key_ready[i], in_ready[i]}), 128'(2'b10));
      tick();
      key_valid[i] = 1'b0;
      check($sformatf("u%0d prio{busy,ir}", 1 << i), 128'({busy[i], in_ready[i]}), 128'(2'b10));
      bad = 0;
      while (!in_ready[i] && bad < 200) begin tick(); bad++; end
      in_valid[i] = 1'b0;
      check($sformatf("u%0d prio keyexp_latency", 1 << i), 128'(bad), 128'(32 >> i));
      run_block(i, blk, 1'b1, 1, res);
      check($sformatf("u%0d zero_key enc", 1 << i), res, sm4_model('0, blk, 1'b1));
    end

    // reset in the middle of a run (UNROLL=1, round 17)
    load_key(0, GOLD_KEY);
    din[0] = GOLD_KEY; mode[0] = 1'b1; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (17) tick();
    check("u1 midrun{busy,ov}", 128'({busy[0], out_valid[0]}), 128'(2'b10));
    rst[0] = 1'b1;
    tick();
    check("u1 midrun_rst{kr,ir,ov,busy}",
          128'({key_ready[0], in_ready[0], out_valid[0], busy[0]}), 128'(4'b1000));
    check("u1 midrun_rst dout", dout[0], '0);
    rst[0] = 1'b0;
    din[0] = rand128(); mode[0] = 1'b1; in_valid[0] = 1'b1;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (in_ready[0] || out_valid[0] || busy[0]) bad++;
    end
    in_valid[0] = 1'b0;
    check("u1 no_key block_ignored", 128'(bad), '0);
    check("u1 still idle kr", 128'(key_ready[0]), 128'(1));

    // randomized key/block pairs, alternating mode, each result fed back the other way
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < N_RAND[i]; n++) begin
        k   = rand128();
        blk = rand128();
        load_key(i, k);
        run_block(i, blk, n[0], int'($urandom_range(0, 3)), res);
        check($sformatf("u%0d rand%0d", 1 << i, n), res, sm4_model(k, blk, n[0]));
        run_block(i, res, ~n[0], int'($urandom_range(0, 3)), res2);
        check($sformatf("u%0d rand%0d back", 1 << i, n), res2, blk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
